// File: rtl/imem_access_ctrl.sv
// imem_access_ctrl: arbitrates the single-port imem between fetch and loader.
// Boot/reload sessions write from address 0 upward; fetch stalls meanwhile.
module imem_access_ctrl #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter bit BOOT_LOAD = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_en,
    input  logic              ld_req,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ack,
    output logic              ld_err,
    output logic [ADDR_W:0]   ld_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic              pc_write_en,
    output logic              instr_valid,
    output logic              core_en
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        PAUSE,
        RESUME
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W:0]   wr_ptr;
    logic              err_q;
    logic              rd_pending;
    logic              full;
    logic              wr_inc;
    logic              err_set;
    logic              sess_clr;

    // Pointer saturates at 2^ADDR_W; the top bit doubles as the full flag.
    assign full        = wr_ptr[ADDR_W];
    assign ld_count    = wr_ptr;
    assign ld_err      = err_q;
    assign instr_valid = rd_pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if (BOOT_LOAD) state <= BOOT;
            else           state <= RUN;
            wr_ptr     <= '0;
            err_q      <= 1'b0;
            rd_pending <= 1'b0;
        end else begin
            state      <= state_nx;
            rd_pending <= mem_rden;
            if (sess_clr) begin
                wr_ptr <= '0;
                err_q  <= 1'b0;
            end else begin
                if (wr_inc)  wr_ptr <= wr_ptr + 1'b1;
                if (err_set) err_q  <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        mem_addr    = '0;
        mem_data    = '0;
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;
        ld_ack      = 1'b0;
        pc_write_en = 1'b0;
        core_en     = 1'b1;
        wr_inc      = 1'b0;
        err_set     = 1'b0;
        sess_clr    = 1'b0;
        unique case (state)
            BOOT, PAUSE: begin
                core_en = (state == PAUSE);
                if (ld_req) begin
                    ld_ack = 1'b1;
                    if (!full) begin
                        mem_wren = 1'b1;
                        mem_addr = wr_ptr[ADDR_W-1:0];
                        mem_data = ld_data;
                        wr_inc   = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                    if (ld_last) state_nx = RESUME;
                end
            end
            RUN: begin
                mem_addr    = fetch_addr;
                mem_rden    = fetch_en;
                pc_write_en = !ld_req;
                // The request is only observed here; it is written from PAUSE.
                if (ld_req) begin
                    state_nx = PAUSE;
                    sess_clr = 1'b1;
                end
            end
            RESUME: begin
                mem_addr = fetch_addr;
                mem_rden = 1'b1;
                state_nx = RUN;
            end
        endcase
    end

    a_rw_excl: assert property (
        @(posedge clk) disable iff (!rst) !(mem_rden && mem_wren)
    );

endmodule
